// File: rtl/qqspi_pkg.sv
// qqspi_pkg: command codes, dummy-cycle count and state encoding for the quad-SPI target.
// Rev 1.0
`default_nettype none
package qqspi_pkg;
  localparam logic [7:0] CMD_WRITE          = 8'h02;
  localparam logic [7:0] CMD_READ           = 8'h03;
  localparam logic [7:0] CMD_QUAD_WRITE     = 8'h38;
  localparam logic [7:0] CMD_FAST_READ_QUAD = 8'hEB;
  localparam int         DUMMY_CYCLES       = 6;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE
  } state_t;
endpackage
`default_nettype wire

// File: rtl/qqspi_if.sv
// qqspi_if: SPI pad bundle plus byte-wide memory port of the quad-SPI target.
// Rev 1.0
`default_nettype none
interface qqspi_if #(
  parameter int ADDR_W = 24
);
  logic              cen;
  logic              sclk;
  logic [3:0]        sio_in;
  logic [3:0]        sio_out;
  logic [3:0]        sio_oe;
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready;
  logic [7:0]        mem_rdata;
  logic              underrun;
  logic              busy;

  modport slave (
    input  cen, sclk, sio_in, mem_ready, mem_rdata,
    output sio_out, sio_oe, mem_valid, mem_we, mem_addr, mem_wdata, underrun, busy
  );

  modport master (
    output cen, sclk, sio_in, mem_ready, mem_rdata,
    input  sio_out, sio_oe, mem_valid, mem_we, mem_addr, mem_wdata, underrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/qqspi_edge_sync.sv
// qqspi_edge_sync: two-flop synchronisers for sclk/cen with sclk edge detection.
// Rev 1.0
`default_nettype none
module qqspi_edge_sync #(
  parameter bit CEN_NPOL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic sclk,
  input  logic cen,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cen_act
);
  logic [2:0] sclk_sync;
  logic [1:0] cen_sync;

  // sclk idles high and cen idles inactive, so reset to those levels
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_sync <= 3'b111;
      cen_sync  <= {2{~CEN_NPOL}};
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      cen_sync  <= {cen_sync[0], cen};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cen_act   = cen_sync[1] ^ ~CEN_NPOL;
endmodule
`default_nettype wire

// File: rtl/qqspi_target.sv
// qqspi_target: oversampling SPI/QPI target mapping commands 02/03/38/EB onto a byte memory port.
// Rev 1.0
`default_nettype none
module qqspi_target
  import qqspi_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter bit CEN_NPOL = 1'b0,
  parameter bit QUAD_EN  = 1'b1
) (
  input logic  clk,
  input logic  resetn,
  qqspi_if.slave bus
);
  state_t            state, next_state;
  logic              sclk_rise, sclk_fall, cen_act, rise, fall;
  logic [3:0]        sio_s1, sio_s2;
  logic [4:0]        cnt;
  logic [23:0]       shreg, addr_full;
  logic [7:0]        cmd, cmd_byte, wsh, wbyte, out_sh, rd_buf;
  logic              quad, rd_valid, discard;
  logic              cmd_single, cmd_quad, cmd_is_write, addr_last, byte_last;
  logic [ADDR_W-1:0] addr;
  logic              mem_valid, mem_we, underrun;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  qqspi_edge_sync #(.CEN_NPOL(CEN_NPOL)) u_sync (
    .clk(clk), .resetn(resetn), .sclk(bus.sclk), .cen(bus.cen),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cen_act(cen_act)
  );

  // same depth as the sclk path so data lines up with the detected rise
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sio_s1 <= 4'h0;
      sio_s2 <= 4'h0;
    end else begin
      sio_s1 <= bus.sio_in;
      sio_s2 <= sio_s1;
    end
  end

  assign rise         = sclk_rise & cen_act;
  assign fall         = sclk_fall & cen_act;
  assign cmd_byte     = {shreg[6:0], sio_s2[0]};
  assign cmd_single   = (cmd_byte == CMD_WRITE) || (cmd_byte == CMD_READ);
  assign cmd_quad     = QUAD_EN && ((cmd_byte == CMD_QUAD_WRITE) || (cmd_byte == CMD_FAST_READ_QUAD));
  assign cmd_is_write = (cmd == CMD_WRITE) || (cmd == CMD_QUAD_WRITE);
  assign addr_full    = quad ? {shreg[19:0], sio_s2} : {shreg[22:0], sio_s2[0]};
  assign addr_last    = (cnt == (quad ? 5'd5 : 5'd23));
  assign byte_last    = (cnt == (quad ? 5'd1 : 5'd7));
  assign wbyte        = quad ? {wsh[3:0], sio_s2} : {wsh[6:0], sio_s2[0]};

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!cen_act) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = CMD;
        CMD:     if (rise && cnt == 5'd7) next_state = (cmd_single || cmd_quad) ? ADDR : IGNORE;
        ADDR:    if (rise && addr_last)
                   next_state = cmd_is_write ? WDATA : ((cmd == CMD_READ) ? RDATA : DUMMY);
        DUMMY:   if (rise && cnt == 5'(DUMMY_CYCLES - 1)) next_state = RDATA;
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0; shreg <= '0; cmd <= '0; quad <= 1'b0; addr <= '0;
      wsh <= '0; out_sh <= '0; rd_buf <= '0; rd_valid <= 1'b0; discard <= 1'b0;
      mem_valid <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0; underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (mem_valid && bus.mem_ready) begin
        mem_valid <= 1'b0;
        discard   <= 1'b0;
        if (!mem_we && !discard) begin
          rd_buf   <= bus.mem_rdata;
          rd_valid <= 1'b1;
        end
      end
      if (!cen_act || state == IDLE) begin
        cnt <= '0; shreg <= '0; quad <= 1'b0; out_sh <= '0; rd_valid <= 1'b0;
        // a request still outstanding belongs to the abandoned transaction
        if (mem_valid && !bus.mem_ready) discard <= 1'b1;
      end else begin
        case (state)
          CMD: if (rise) begin
            if (cnt == 5'd7) begin
              cmd <= cmd_byte; quad <= cmd_quad; cnt <= '0; shreg <= '0;
            end else begin
              shreg <= {shreg[22:0], sio_s2[0]}; cnt <= cnt + 5'd1;
            end
          end
          ADDR: if (rise) begin
            shreg <= addr_full;
            if (addr_last) begin
              cnt  <= '0;
              addr <= ADDR_W'(addr_full);
              if (!cmd_is_write && !mem_valid) begin
                mem_valid <= 1'b1; mem_we <= 1'b0; mem_addr <= ADDR_W'(addr_full);
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          DUMMY: if (rise) cnt <= (cnt == 5'(DUMMY_CYCLES - 1)) ? 5'd0 : cnt + 5'd1;
          WDATA: if (rise) begin
            wsh <= wbyte;
            if (byte_last) begin
              cnt <= '0;
              if (mem_valid) begin
                underrun <= 1'b1;
              end else begin
                mem_valid <= 1'b1; mem_we <= 1'b1; mem_addr <= addr; mem_wdata <= wbyte;
                addr <= addr + ADDR_W'(1);
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          RDATA: if (fall) begin
            cnt <= byte_last ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd0) begin
              if (rd_valid) begin
                out_sh   <= rd_buf;
                rd_valid <= 1'b0;
                addr     <= addr + ADDR_W'(1);
                if (!mem_valid) begin
                  mem_valid <= 1'b1; mem_we <= 1'b0; mem_addr <= addr + ADDR_W'(1);
                end
              end else begin
                // late prefetch: emit zeros; refetch only if nothing is in flight
                out_sh   <= 8'h00;
                underrun <= 1'b1;
                if (!mem_valid) begin
                  mem_valid <= 1'b1; mem_we <= 1'b0; mem_addr <= addr;
                end
              end
            end else begin
              out_sh <= quad ? {out_sh[3:0], 4'h0} : {out_sh[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sio_oe    = (state == RDATA) ? (quad ? 4'b1111 : 4'b0010) : 4'b0000;
  assign bus.sio_out   = (state == RDATA) ? (quad ? out_sh[7:4] : {2'b00, out_sh[7], 1'b0}) : 4'b0000;
  assign bus.mem_valid = mem_valid;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.underrun  = underrun;
  assign bus.busy      = (state != IDLE);
endmodule
`default_nettype wire
